// File: rtl/the_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// the_mem_wb_stage
//
// Purpose:
//   Memory stage of a 5-stage MIPS datapath. It sits after the EX/MEM
//   pipeline register and does four things:
//     - resolves branches (pcsrc / branch_target),
//     - performs word loads and stores to a local data memory,
//     - raises mem_stall while an access is in progress,
//     - captures results into the MEM/WB pipeline register.
//   Each access takes MEM_LATENCY extra wait cycles. Accesses are not
//   pipelined, so every load or store pays its full latency.
//
// Parameters:
//   DEPTH_WORDS : data memory size in 32-bit words (power of two).
//   MEM_LATENCY : extra wait cycles per load/store (0..15). A value of 0
//                 gives single-cycle access.
//
// Optional feature (macro MEM_MISALIGN_TRAP_EN):
//   When defined, the block adds a registered `misalign` output. An access
//   whose byte offset is non-zero sets misalign=1, suppresses the write,
//   returns read data 0 and forces ctl_wb_out to 00. Stall timing does not
//   change.
//   When undefined, the port is absent and address bits [1:0] are ignored.
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-low reset
//   ctl_wb_in       in   {RegWrite, MemtoReg} from EX/MEM
//   ctl_mem_in      in   {Branch, MemRead, MemWrite} from EX/MEM
//   add_result_in   in   branch target
//   zero_in         in   ALU zero flag
//   alu_result_in   in   byte address, or ALU result for non-memory ops
//   rdata2_in       in   store data
//   write_reg_in    in   destination register number
//   pcsrc           out  Branch & zero_in (combinational)
//   branch_target   out  add_result_in passthrough
//   mem_stall       out  high while upstream must hold EX/MEM contents
//   ctl_wb_out      out  MEM/WB control
//   read_data_out   out  MEM/WB load data
//   alu_result_out  out  MEM/WB ALU result
//   write_reg_out   out  MEM/WB destination register
//   misalign        out  MEM/WB misalignment flag (optional)
// ---------------------------------------------------------------------------
module the_mem_wb_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ctl_wb_in,
    input  logic [2:0]  ctl_mem_in,
    input  logic [31:0] add_result_in,
    input  logic        zero_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rdata2_in,
    input  logic [4:0]  write_reg_in,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        mem_stall,
    output logic [1:0]  ctl_wb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic [4:0]  write_reg_out,
    output logic        misalign
`else
    output logic [4:0]  write_reg_out
`endif
);

    localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
    localparam bit         HAS_WAIT = (MEM_LATENCY > 0);
    localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(MEM_LATENCY - 1) : 4'd0;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic [1:0]  ctl_wb;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  write_reg;
`ifdef MEM_MISALIGN_TRAP_EN
        logic        misalign;
`endif
    } mem_wb_t;

    logic              branch;
    logic              mem_read;
    logic              mem_write;
    logic              access;
    logic              is_load;
    logic              trap;
    logic              complete;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;

    state_t            state_q;
    logic [3:0]        cnt_q;
    mem_wb_t           mem_wb_d;
    mem_wb_t           mem_wb_q;

    logic [31:0]       mem_q [DEPTH_WORDS];

    // ---------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------
    assign branch    = ctl_mem_in[2];
    assign mem_read  = ctl_mem_in[1];
    assign mem_write = ctl_mem_in[0];
    assign access    = mem_read | mem_write;
    // When both MemRead and MemWrite are set, the op counts as a write.
    assign is_load   = mem_read & ~mem_write;

    // Address bits above the array size are dropped, so addresses wrap.
    assign word_idx  = alu_result_in[ADDR_W+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = access & (alu_result_in[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    // Branch resolution does not depend on the access FSM.
    assign pcsrc         = branch & zero_in;
    assign branch_target = add_result_in;

    // The access completes at the coming edge in two cases:
    //   - in WAIT, once the counter has reached zero;
    //   - in IDLE, when no wait cycles are needed.
    // Upstream must hold its contents in every other cycle.
    assign complete  = (state_q == S_WAIT) ? (cnt_q == 4'd0)
                                           : (!access || !HAS_WAIT);
    assign mem_stall = ~complete;

    // ---------------------------------------------------------------------
    // Data memory: asynchronous read, write at the completing edge
    // ---------------------------------------------------------------------
    assign rd_word = mem_q[word_idx];

    // NOTE: the memory array has no reset branch. Its contents survive
    // reset, and leaving the reset out lets the array map onto RAM.
    // Reset only blocks the write so that an abandoned access has no effect.
    always_ff @(posedge clk) begin
        if (reset && complete && mem_write && !trap) begin
            mem_q[word_idx] <= rdata2_in;
        end
    end

    // ---------------------------------------------------------------------
    // MEM/WB contents for the instruction currently presented
    // ---------------------------------------------------------------------
    // NOTE: every field gets a default before any conditional assignment,
    // so this combinational block cannot infer a latch.
    always_comb begin
        mem_wb_d            = '0;
        mem_wb_d.ctl_wb     = trap ? 2'b00 : ctl_wb_in;
        mem_wb_d.read_data  = (is_load && !trap) ? rd_word : 32'd0;
        mem_wb_d.alu_result = alu_result_in;
        mem_wb_d.write_reg  = write_reg_in;
`ifdef MEM_MISALIGN_TRAP_EN
        mem_wb_d.misalign   = trap;
`endif
    end

    // ---------------------------------------------------------------------
    // Access FSM and MEM/WB register. Wait cycles push bubbles (all zero).
    // ---------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments only. Every
    // register then samples values from before the edge, whatever order
    // the statements appear in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            mem_wb_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (access && HAS_WAIT) begin
                        state_q  <= S_WAIT;
                        cnt_q    <= CNT_INIT;
                        mem_wb_q <= '0;
                    end else begin
                        mem_wb_q <= mem_wb_d;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q    <= cnt_q - 4'd1;
                        mem_wb_q <= '0;
                    end else begin
                        state_q  <= S_IDLE;
                        mem_wb_q <= mem_wb_d;
                    end
                end
            endcase
        end
    end

    assign ctl_wb_out     = mem_wb_q.ctl_wb;
    assign read_data_out  = mem_wb_q.read_data;
    assign alu_result_out = mem_wb_q.alu_result;
    assign write_reg_out  = mem_wb_q.write_reg;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign       = mem_wb_q.misalign;
`endif

endmodule

// File: tb/tb_the_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// Testbench for the_mem_wb_stage.
//
// Three instances share one clock and reset:
//   index 0 -> MEM_LATENCY = 0
//   index 1 -> MEM_LATENCY = 2
//   index 2 -> MEM_LATENCY = 3
// The do_op task drives one instruction into a chosen instance and pushes
// its expected MEM/WB result onto a queue. It checks mem_stall and the
// bubble contents on every wait cycle, then pops the expected entry and
// compares it when the result appears.
// ---------------------------------------------------------------------------
module tb_the_mem_wb_stage;

    localparam int LAT_TAB [3] = '{0, 2, 3};

    typedef struct packed {
        logic [1:0]  ctl_wb;
        logic [2:0]  ctl_mem;
        logic [31:0] add_result;
        logic        zero;
        logic [31:0] alu_result;
        logic [31:0] wdata;
        logic [4:0]  wreg;
    } in_t;

    typedef struct {
        int          dut;
        logic [1:0]  ctl_wb;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  wreg;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        reset;
    in_t         din     [3];
    logic        pcsrc_o [3];
    logic [31:0] btgt_o  [3];
    logic        stall_o [3];
    logic [1:0]  wb_o    [3];
    logic [31:0] rd_o    [3];
    logic [31:0] alu_o   [3];
    logic [4:0]  wr_o    [3];
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mis_o   [3];
`endif

    exp_t exp_q [$];
    int   checks    = 0;
    int   errors    = 0;
    int   stall_cnt = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        the_mem_wb_stage #(
            .DEPTH_WORDS (256),
            .MEM_LATENCY (LAT_TAB[g])
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .ctl_wb_in      (din[g].ctl_wb),
            .ctl_mem_in     (din[g].ctl_mem),
            .add_result_in  (din[g].add_result),
            .zero_in        (din[g].zero),
            .alu_result_in  (din[g].alu_result),
            .rdata2_in      (din[g].wdata),
            .write_reg_in   (din[g].wreg),
            .pcsrc          (pcsrc_o[g]),
            .branch_target  (btgt_o[g]),
            .mem_stall      (stall_o[g]),
            .ctl_wb_out     (wb_o[g]),
            .read_data_out  (rd_o[g]),
            .alu_result_out (alu_o[g]),
`ifdef MEM_MISALIGN_TRAP_EN
            .write_reg_out  (wr_o[g]),
            .misalign       (mis_o[g])
`else
            .write_reg_out  (wr_o[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic in_t mk(input logic [1:0] wb, input logic [2:0] mem,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] wr);
        in_t r;
        r            = '0;
        r.ctl_wb     = wb;
        r.ctl_mem    = mem;
        r.alu_result = alu;
        r.wdata      = wd;
        r.wreg       = wr;
        return r;
    endfunction

    // Scoreboard driver/monitor for a single instruction on instance d.
    task automatic do_op(input int d, input in_t op, input logic [31:0] exp_rd);
        exp_t e;
        exp_t got;
        logic acc;
        logic mis;
        logic exp_stall;
        int   n;
        acc = op.ctl_mem[1] | op.ctl_mem[0];
        n   = acc ? LAT_TAB[d] : 0;
        mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = acc && (op.alu_result[1:0] != 2'b00);
`endif
        @(negedge clk);
        din[d]       = op;
        e.dut        = d;
        e.ctl_wb     = mis ? 2'b00 : op.ctl_wb;
        e.read_data  = mis ? 32'd0 : exp_rd;
        e.alu_result = op.alu_result;
        e.wreg       = op.wreg;
        e.mis        = mis;
        exp_q.push_back(e);
        for (int k = 0; k <= n; k++) begin
            #1;
            exp_stall = (k < n);
            checks++;
            if (stall_o[d] !== exp_stall) begin
                errors++;
                $display("FAIL mem_stall dut%0d cyc%0d: got %b exp %b", d, k, stall_o[d], exp_stall);
            end
            if (stall_o[d] === 1'b1) stall_cnt++;
            checks++;
            if (pcsrc_o[d] !== (op.ctl_mem[2] & op.zero)) begin
                errors++;
                $display("FAIL pcsrc dut%0d: got %b exp %b", d, pcsrc_o[d], op.ctl_mem[2] & op.zero);
            end
            checks++;
            if (btgt_o[d] !== op.add_result) begin
                errors++;
                $display("FAIL branch_target dut%0d: got %h exp %h", d, btgt_o[d], op.add_result);
            end
            @(posedge clk);
            #1;
            if (k < n) begin
                checks++;
                if ({wb_o[d], rd_o[d], alu_o[d], wr_o[d]} !== '0) begin
                    errors++;
                    $display("FAIL bubble dut%0d cyc%0d: got wb=%b rd=%h alu=%h wr=%0d exp all 0",
                             d, k, wb_o[d], rd_o[d], alu_o[d], wr_o[d]);
                end
            end else begin
                got = exp_q.pop_front();
                checks++;
                if (wb_o[got.dut] !== got.ctl_wb) begin
                    errors++;
                    $display("FAIL ctl_wb_out dut%0d: got %b exp %b", d, wb_o[got.dut], got.ctl_wb);
                end
                checks++;
                if (rd_o[got.dut] !== got.read_data) begin
                    errors++;
                    $display("FAIL read_data_out dut%0d: got %h exp %h", d, rd_o[got.dut], got.read_data);
                end
                checks++;
                if (alu_o[got.dut] !== got.alu_result) begin
                    errors++;
                    $display("FAIL alu_result_out dut%0d: got %h exp %h", d, alu_o[got.dut], got.alu_result);
                end
                checks++;
                if (wr_o[got.dut] !== got.wreg) begin
                    errors++;
                    $display("FAIL write_reg_out dut%0d: got %0d exp %0d", d, wr_o[got.dut], got.wreg);
                end
`ifdef MEM_MISALIGN_TRAP_EN
                checks++;
                if (mis_o[got.dut] !== got.mis) begin
                    errors++;
                    $display("FAIL misalign dut%0d: got %b exp %b", d, mis_o[got.dut], got.mis);
                end
`endif
            end
            if (k < n) @(negedge clk);
        end
        din[d] = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) din[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({wb_o[i], rd_o[i], alu_o[i], wr_o[i]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got wb=%b rd=%h alu=%h wr=%0d exp all 0",
                         i, wb_o[i], rd_o[i], alu_o[i], wr_o[i]);
            end
            checks++;
            if (stall_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_stall dut%0d: got %b exp 0", i, stall_o[i]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_lat0_store_load();
        do_op(0, mk(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0), 32'd0);
        do_op(0, mk(2'b11, 3'b010, 32'h10, 32'd0, 5'd8), 32'hDEADBEEF);
    endtask

    task automatic test_latency2();
        do_op(1, mk(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0), 32'd0);
        do_op(1, mk(2'b11, 3'b010, 32'h10, 32'd0, 5'd9), 32'hDEADBEEF);
        stall_cnt = 0;
        do_op(1, mk(2'b11, 3'b010, 32'h10, 32'd0, 5'd10), 32'hDEADBEEF);
        do_op(1, mk(2'b11, 3'b010, 32'h10, 32'd0, 5'd11), 32'hDEADBEEF);
        checks++;
        if (stall_cnt !== 4) begin
            errors++;
            $display("FAIL back_to_back_stalls: got %0d exp 4", stall_cnt);
        end
        // Read+write together counts as a write and returns no data.
        do_op(1, mk(2'b11, 3'b011, 32'h30, 32'hCAFEF00D, 5'd12), 32'd0);
        do_op(1, mk(2'b11, 3'b010, 32'h30, 32'd0, 5'd13), 32'hCAFEF00D);
    endtask

    task automatic test_branch();
        in_t op;
        op            = mk(2'b00, 3'b100, 32'h0, 32'h0, 5'd0);
        op.add_result = 32'h40;
        op.zero       = 1'b1;
        do_op(0, op, 32'd0);
        op.zero       = 1'b0;
        do_op(0, op, 32'd0);
    endtask

    task automatic test_alu_passthrough();
        do_op(2, mk(2'b10, 3'b000, 32'h1234ABCD, 32'h0, 5'd3), 32'd0);
    endtask

    task automatic test_reset_abort();
        do_op(2, mk(2'b00, 3'b001, 32'h20, 32'h11111111, 5'd0), 32'd0);
        @(negedge clk);
        din[2] = mk(2'b00, 3'b001, 32'h20, 32'h12345678, 5'd0);
        #1;
        checks++;
        if (stall_o[2] !== 1'b1) begin
            errors++;
            $display("FAIL abort_stall1: got %b exp 1", stall_o[2]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall_o[2] !== 1'b1) begin
            errors++;
            $display("FAIL abort_stall2: got %b exp 1", stall_o[2]);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({wb_o[2], rd_o[2], alu_o[2], wr_o[2]} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got wb=%b rd=%h alu=%h wr=%0d exp all 0",
                     wb_o[2], rd_o[2], alu_o[2], wr_o[2]);
        end
        din[2] = '0;
        #1;
        checks++;
        if (stall_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got stall %b exp 0", stall_o[2]);
        end
        @(negedge clk);
        reset = 1'b1;
        do_op(2, mk(2'b11, 3'b010, 32'h20, 32'd0, 5'd7), 32'h11111111);
    endtask

    task automatic test_wrap();
        do_op(0, mk(2'b00, 3'b001, 32'h400, 32'hA5A5A5A5, 5'd0), 32'd0);
        do_op(0, mk(2'b11, 3'b010, 32'h000, 32'd0, 5'd4), 32'hA5A5A5A5);
    endtask

    task automatic test_misalign();
        logic [31:0] exp_word;
`ifdef MEM_MISALIGN_TRAP_EN
        exp_word = 32'hDEADBEEF;
`else
        exp_word = 32'h55AA55AA;
`endif
        do_op(0, mk(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0), 32'd0);
        do_op(0, mk(2'b00, 3'b001, 32'h13, 32'h55AA55AA, 5'd0), 32'd0);
        do_op(0, mk(2'b11, 3'b010, 32'h10, 32'd0, 5'd5), exp_word);
    endtask

    initial begin
        test_reset();
        test_lat0_store_load();
        test_latency2();
        test_branch();
        test_alu_passthrough();
        test_reset_abort();
        test_wrap();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
